xillyvga_capture: RTL and testbench
===================================

// Module: xillyvga_capture
// PURPOSE
//  Video capture path, the write-side counterpart of the framebuffer display path. Accepts a
//  parallel RGB pixel stream with DE/VSYNC and packs each pixel to a 32-bit word {8'h00,R,G,B}.
//  Buffers words in an internal FIFO and writes each frame to memory through AXI3 INCR bursts
//  on the write channels of an AXI master. Sits beside the display core on the same interconnect port.
// PARAMETERS
//  C_M_AXI_ADDR_WIDTH  32  master address width
//  C_M_AXI_DATA_WIDTH  32  master data width (only 32 supported)
//  C_BURST_LEN         16  beats per full burst, 1..16 (AXI3 awlen is 4 bits)
//  C_FIFO_DEPTH        64  pixel FIFO depth in words, power of 2, >= 2*C_BURST_LEN
// PORTS
//  m_axi_aclk     in   1   sole clock; pixel inputs are synchronous to it
//  m_axi_aresetn  in   1   asynchronous, active-low reset
//  cap_enable     in   1   capture enable (level)
//  cap_base       in   32  frame base byte address; bits [5:0] ignored (forced 0)
//  cap_words      in   24  pixels per frame; 0 = frame completes immediately on start
//  vid_vsync      in   1   frame start marker; rising edge starts a frame
//  vid_de         in   1   pixel valid
//  vid_red/green/blue  in  8 each  pixel components
//  m_axi_awaddr   out  32  burst address      | m_axi_awlen   out 4  beats-1
//  m_axi_awvalid  in/out handshake: awvalid out 1, m_axi_awready in 1
//  m_axi_awburst/awsize/awcache/awprot  out 2/3/4/3  constants 2'b01, 3'b010, 4'b0011, 3'b000
//  m_axi_wdata    out  32  FIFO head          | m_axi_wstrb   out 4  constant 4'hF
//  m_axi_wvalid   out  1   | m_axi_wlast out 1 | m_axi_wready in 1
//  m_axi_bvalid   in   1   | m_axi_bresp in 2  | m_axi_bready out 1
//  cap_busy       out  1   high from frame start until final response
//  cap_frame_done out  1   one-cycle pulse after last burst response of a frame
//  cap_overflow   out  1   sticky: pixel dropped on full FIFO; cleared while cap_enable=0
//  cap_resp_err   out  1   sticky: bresp!=OKAY seen; cleared while cap_enable=0
// BEHAVIOUR
//  Reset: all outputs 0 except the constant AXI fields; FSM IDLE; FIFO empty; counters 0.
//  FSM: IDLE -> (cap_enable & vsync rise) -> FILL: latch cap_base, cap_words; push_cnt/issue_cnt=0.
//  FILL -> ADDR when fifo_cnt>=C_BURST_LEN, or fifo_cnt>=remaining where remaining<C_BURST_LEN.
//   remaining = cap_words-issue_cnt.
//  ADDR: awvalid=1, awaddr=base+4*issue_cnt, awlen=min(C_BURST_LEN,remaining)-1; held stable until awready.
//  DATA: wvalid=1 while the burst is in progress; pop on wvalid&wready; wlast on final beat.
//   Beats never stall on empty FIFO (count was checked in FILL).
//  RESP: bready=1; on bvalid: issue_cnt+=len and set resp_err if bresp!=2'b00.
//   Then DONE if issue_cnt==cap_words, else FILL if cap_enable, else FLUSH.
//  DONE: cap_frame_done=1 for one cycle -> IDLE. FLUSH: empty FIFO in one cycle -> IDLE.
//  Push: in FILL..RESP, push when vid_de and push_cnt<cap_words.
//   Pixels beyond cap_words are dropped silently; pixels outside a frame are ignored.
//  Full FIFO & vid_de & push allowed: pixel dropped, cap_overflow set; push_cnt still increments.
//   Frame length is preserved; a dropped word leaves fifo short, so the final burst is sized from
//   pushed data: remaining target = words actually queued. Frame completes when
//   issue_cnt == push_cnt_stored and push_cnt==cap_words.
//  Vsync rise while busy: ignored (no restart). Push and pop in the same cycle: fifo_cnt unchanged.
//  cap_enable low mid-frame: current burst runs to RESP, then FLUSH; no frame_done.
//  Bursts are 64-byte aligned when C_BURST_LEN=16, so they never cross 4 KB.
//  issue_cnt wraps mod 2^24; addresses wrap mod 2^32.
//  Async reset mid-burst: immediate return to reset state; the interconnect is reset alongside.
// CONFIGURATION
//  XILLYVGA_CAP_DBLBUF_EN defined: adds input cap_base_alt[31:0] and output cap_buf_sel.
//   Frames alternate between cap_base and cap_base_alt, starting with cap_base after reset.
//   cap_buf_sel reports the buffer of the last completed frame and toggles with cap_frame_done.
//  Not defined: every frame goes to cap_base; no extra ports.
// TESTING
//  base=0x1000_0000, words=32, 32 DE pixels -> 2 bursts, awaddr 0x1000_0000/0x1000_0040, awlen=15, frame_done once.
//  words=20 -> bursts awlen=15 then awlen=3 at +0x40; wlast on beat 16 and beat 4; data {00,R,G,B} in order.
//  awready delayed 5 cycles, wready toggling 50% -> awaddr/awlen/wdata stable while stalled; no beat lost.
//  bresp=2'b10 on first burst -> cap_resp_err=1; frame still completes; cleared after cap_enable=0.
//  wready=0 for 200 cycles, DE continuous, depth 64 -> cap_overflow=1; no hang; frame_done still pulses.
//  cap_enable dropped mid-frame / reset mid-DATA -> burst completes then IDLE without frame_done /
//   all outputs to reset values.

Source files
------------

// File: rtl/xillyvga_capture.sv
// Purpose : video capture; packs RGB pixels to {8'h00,R,G,B}, queues them and writes each frame to memory as AXI3 INCR bursts.
// Latency : a pixel reaches the W channel no earlier than 3 cycles after it is pushed (FILL check, AW handshake, W beat).
// Backpres: the pixel input is never stalled; pixels that arrive while the FIFO is full are dropped and flagged in cap_overflow.
//
// Ports:
//   m_axi_aclk / m_axi_aresetn  sole clock, asynchronous active-low reset
//   cap_enable, cap_base, cap_words          capture control (level enable, frame base, pixels per frame)
//   vid_vsync, vid_de, vid_red/green/blue    pixel stream synchronous to m_axi_aclk
//   m_axi_aw* / m_axi_w* / m_axi_b*          AXI3 write-channel master (32-bit data)
//   cap_busy, cap_frame_done, cap_overflow, cap_resp_err   status
// Optional build macro XILLYVGA_CAP_DBLBUF_EN adds cap_base_alt / cap_buf_sel:
// frames alternate between cap_base and cap_base_alt, starting with cap_base.

module xillyvga_capture_fifo #(
    parameter int W     = 32,
    parameter int DEPTH = 64
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     clr,
    input  logic                     push,
    input  logic [W-1:0]             din,
    input  logic                     pop,
    output logic [W-1:0]             dout,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full
);
    // Generic single-clock FIFO; head is visible on dout while count > 0.
    // Zero-cycle read latency (dout follows rd pointer).
    // Caller must not push when full nor pop when empty.
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   cnt_q, cnt_d;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (clr) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            cnt_d    = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + AW'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
            if (push && !pop)      cnt_d = cnt_q + (AW+1)'(1);
            else if (pop && !push) cnt_d = cnt_q - (AW+1)'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    // Storage needs no reset: pointers and count define validity.
    always_ff @(posedge clk) begin
        if (push && !clr) mem_q[wr_ptr_q] <= din;
    end

    assign dout  = mem_q[rd_ptr_q];
    assign count = cnt_q;
    assign full  = (cnt_q == (AW+1)'(DEPTH));
endmodule

module xillyvga_capture #(
    parameter int C_M_AXI_ADDR_WIDTH = 32,
    parameter int C_M_AXI_DATA_WIDTH = 32,
    parameter int C_BURST_LEN        = 16,
    parameter int C_FIFO_DEPTH       = 64
) (
    input  logic                          m_axi_aclk,
    input  logic                          m_axi_aresetn,
    input  logic                          cap_enable,
    input  logic [C_M_AXI_ADDR_WIDTH-1:0] cap_base,
`ifdef XILLYVGA_CAP_DBLBUF_EN
    input  logic [C_M_AXI_ADDR_WIDTH-1:0] cap_base_alt,
    output logic                          cap_buf_sel,
`endif
    input  logic [23:0]                   cap_words,
    input  logic                          vid_vsync,
    input  logic                          vid_de,
    input  logic [7:0]                    vid_red,
    input  logic [7:0]                    vid_green,
    input  logic [7:0]                    vid_blue,
    output logic [C_M_AXI_ADDR_WIDTH-1:0] m_axi_awaddr,
    output logic [3:0]                    m_axi_awlen,
    output logic                          m_axi_awvalid,
    input  logic                          m_axi_awready,
    output logic [1:0]                    m_axi_awburst,
    output logic [2:0]                    m_axi_awsize,
    output logic [3:0]                    m_axi_awcache,
    output logic [2:0]                    m_axi_awprot,
    output logic [C_M_AXI_DATA_WIDTH-1:0] m_axi_wdata,
    output logic [3:0]                    m_axi_wstrb,
    output logic                          m_axi_wvalid,
    output logic                          m_axi_wlast,
    input  logic                          m_axi_wready,
    input  logic                          m_axi_bvalid,
    input  logic [1:0]                    m_axi_bresp,
    output logic                          m_axi_bready,
    output logic                          cap_busy,
    output logic                          cap_frame_done,
    output logic                          cap_overflow,
    output logic                          cap_resp_err
);
    localparam int                            CW       = $clog2(C_FIFO_DEPTH) + 1;
    localparam logic [4:0]                    BL5      = 5'(C_BURST_LEN);
    localparam logic [23:0]                   BL24     = 24'(C_BURST_LEN);
    localparam logic [C_M_AXI_ADDR_WIDTH-1:0] LOW_BITS = C_M_AXI_ADDR_WIDTH'(63);

    typedef enum logic [2:0] {S_IDLE, S_FILL, S_ADDR, S_DATA, S_RESP, S_DONE, S_FLUSH} state_t;

    state_t                          state_q, state_d;
    logic                            vsync_q, vsync_d;
    logic [C_M_AXI_ADDR_WIDTH-1:0]   base_q, base_d;
    logic [23:0]                     words_q, words_d;
    logic [23:0]                     push_cnt_q, push_cnt_d;
    logic [23:0]                     drop_cnt_q, drop_cnt_d;
    logic [23:0]                     issue_cnt_q, issue_cnt_d;
    logic [4:0]                      burst_len_q, burst_len_d;
    logic [4:0]                      beat_q, beat_d;
    logic                            awvalid_q, awvalid_d;
    logic [C_M_AXI_ADDR_WIDTH-1:0]   awaddr_q, awaddr_d;
    logic [3:0]                      awlen_q, awlen_d;
    logic                            wvalid_q, wvalid_d;
    logic                            wlast_q, wlast_d;
    logic                            bready_q, bready_d;
    logic                            busy_q, busy_d;
    logic                            frame_done_q, frame_done_d;
    logic                            overflow_q, overflow_d;
    logic                            resp_err_q, resp_err_d;
`ifdef XILLYVGA_CAP_DBLBUF_EN
    logic                            next_buf_q, next_buf_d;
    logic                            buf_sel_q, buf_sel_d;
`endif

    logic                            fifo_push, fifo_pop, fifo_clr, fifo_full;
    logic [CW-1:0]                   fifo_cnt;
    logic [C_M_AXI_DATA_WIDTH-1:0]   fifo_head, pix_word;
    logic [C_M_AXI_ADDR_WIDTH-1:0]   sel_base;
    logic                            in_frame, vsync_rise, complete;
    logic [23:0]                     fifo_cnt24, rem_now, issue_next;
    logic [4:0]                      len_sel;

    assign pix_word   = {8'h00, vid_red, vid_green, vid_blue};
    assign vsync_rise = vid_vsync & ~vsync_q;
    assign in_frame   = (state_q == S_FILL) || (state_q == S_ADDR) ||
                        (state_q == S_DATA) || (state_q == S_RESP);
    assign fifo_cnt24 = 24'(fifo_cnt);
    // Words still owed to memory; dropped pixels shrink the frame's write target.
    assign rem_now    = words_q - drop_cnt_q - issue_cnt_q;
    assign issue_next = issue_cnt_q + 24'(burst_len_q);
    assign len_sel    = (rem_now >= BL24) ? BL5 : rem_now[4:0];

`ifdef XILLYVGA_CAP_DBLBUF_EN
    assign sel_base = next_buf_q ? cap_base_alt : cap_base;
`else
    assign sel_base = cap_base;
`endif

    xillyvga_capture_fifo #(
        .W     (C_M_AXI_DATA_WIDTH),
        .DEPTH (C_FIFO_DEPTH)
    ) u_fifo (
        .clk   (m_axi_aclk),
        .rst_n (m_axi_aresetn),
        .clr   (fifo_clr),
        .push  (fifo_push),
        .din   (pix_word),
        .pop   (fifo_pop),
        .dout  (fifo_head),
        .count (fifo_cnt),
        .full  (fifo_full)
    );

    always_comb begin
        state_d      = state_q;
        vsync_d      = vid_vsync;
        base_d       = base_q;
        words_d      = words_q;
        push_cnt_d   = push_cnt_q;
        drop_cnt_d   = drop_cnt_q;
        issue_cnt_d  = issue_cnt_q;
        burst_len_d  = burst_len_q;
        beat_d       = beat_q;
        awvalid_d    = awvalid_q;
        awaddr_d     = awaddr_q;
        awlen_d      = awlen_q;
        wvalid_d     = wvalid_q;
        wlast_d      = wlast_q;
        bready_d     = bready_q;
        frame_done_d = 1'b0;
        overflow_d   = overflow_q;
        resp_err_d   = resp_err_q;
        fifo_push    = 1'b0;
        fifo_pop     = 1'b0;
        fifo_clr     = 1'b0;
        complete     = 1'b0;
`ifdef XILLYVGA_CAP_DBLBUF_EN
        next_buf_d   = next_buf_q;
        buf_sel_d    = buf_sel_q;
`endif

        // Pixel intake: the frame length counts dropped pixels too, so a full FIFO
        // never stretches the frame, it only leaves fewer words to write.
        if (in_frame && vid_de && (push_cnt_q < words_q)) begin
            push_cnt_d = push_cnt_q + 24'd1;
            if (fifo_full) begin
                drop_cnt_d = drop_cnt_q + 24'd1;
                overflow_d = 1'b1;
            end else begin
                fifo_push = 1'b1;
            end
        end

        case (state_q)
            S_IDLE: begin
                if (cap_enable && vsync_rise) begin
                    base_d      = sel_base & ~LOW_BITS;
                    words_d     = cap_words;
                    push_cnt_d  = '0;
                    drop_cnt_d  = '0;
                    issue_cnt_d = '0;
                    if (cap_words == 24'd0) complete = 1'b1;
                    else                    state_d  = S_FILL;
                end
            end
            S_FILL: begin
                if (!cap_enable) begin
                    state_d = S_FLUSH;
                end else if (rem_now == 24'd0) begin
                    // Reached only when the frame's tail was dropped.
                    complete = 1'b1;
                end else if ((fifo_cnt24 >= BL24) || (fifo_cnt24 >= rem_now)) begin
                    // Whole burst is already queued, so W beats never wait on the FIFO.
                    state_d     = S_ADDR;
                    awvalid_d   = 1'b1;
                    awaddr_d    = base_q + C_M_AXI_ADDR_WIDTH'({issue_cnt_q, 2'b00});
                    awlen_d     = 4'(len_sel - 5'd1);
                    burst_len_d = len_sel;
                end
            end
            S_ADDR: begin
                if (m_axi_awready) begin
                    awvalid_d = 1'b0;
                    wvalid_d  = 1'b1;
                    wlast_d   = (burst_len_q == 5'd1);
                    beat_d    = '0;
                    state_d   = S_DATA;
                end
            end
            S_DATA: begin
                if (m_axi_wready) begin
                    fifo_pop = 1'b1;
                    beat_d   = beat_q + 5'd1;
                    if (wlast_q) begin
                        wvalid_d = 1'b0;
                        wlast_d  = 1'b0;
                        bready_d = 1'b1;
                        state_d  = S_RESP;
                    end else begin
                        wlast_d = ((beat_q + 5'd2) == burst_len_q);
                    end
                end
            end
            S_RESP: begin
                if (m_axi_bvalid) begin
                    bready_d    = 1'b0;
                    issue_cnt_d = issue_next;
                    if (m_axi_bresp != 2'b00) resp_err_d = 1'b1;
                    if ((words_q - drop_cnt_d - issue_next) == 24'd0) complete = 1'b1;
                    else if (cap_enable)                                state_d  = S_FILL;
                    else                                                state_d  = S_FLUSH;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            S_FLUSH: begin
                fifo_clr = 1'b1;
                state_d  = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        if (complete) begin
            state_d      = S_DONE;
            frame_done_d = 1'b1;
`ifdef XILLYVGA_CAP_DBLBUF_EN
            buf_sel_d    = next_buf_q;
            next_buf_d   = ~next_buf_q;
`endif
        end

        if (!cap_enable) begin
            overflow_d = 1'b0;
            resp_err_d = 1'b0;
        end

        busy_d = (state_d == S_FILL) || (state_d == S_ADDR) ||
                 (state_d == S_DATA) || (state_d == S_RESP);
    end

    always_ff @(posedge m_axi_aclk or negedge m_axi_aresetn) begin
        if (!m_axi_aresetn) begin
            state_q      <= S_IDLE;
            vsync_q      <= 1'b0;
            base_q       <= '0;
            words_q      <= '0;
            push_cnt_q   <= '0;
            drop_cnt_q   <= '0;
            issue_cnt_q  <= '0;
            burst_len_q  <= '0;
            beat_q       <= '0;
            awvalid_q    <= 1'b0;
            awaddr_q     <= '0;
            awlen_q      <= '0;
            wvalid_q     <= 1'b0;
            wlast_q      <= 1'b0;
            bready_q     <= 1'b0;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
            overflow_q   <= 1'b0;
            resp_err_q   <= 1'b0;
`ifdef XILLYVGA_CAP_DBLBUF_EN
            next_buf_q   <= 1'b0;
            buf_sel_q    <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            vsync_q      <= vsync_d;
            base_q       <= base_d;
            words_q      <= words_d;
            push_cnt_q   <= push_cnt_d;
            drop_cnt_q   <= drop_cnt_d;
            issue_cnt_q  <= issue_cnt_d;
            burst_len_q  <= burst_len_d;
            beat_q       <= beat_d;
            awvalid_q    <= awvalid_d;
            awaddr_q     <= awaddr_d;
            awlen_q      <= awlen_d;
            wvalid_q     <= wvalid_d;
            wlast_q      <= wlast_d;
            bready_q     <= bready_d;
            busy_q       <= busy_d;
            frame_done_q <= frame_done_d;
            overflow_q   <= overflow_d;
            resp_err_q   <= resp_err_d;
`ifdef XILLYVGA_CAP_DBLBUF_EN
            next_buf_q   <= next_buf_d;
            buf_sel_q    <= buf_sel_d;
`endif
        end
    end

    assign m_axi_awaddr   = awaddr_q;
    assign m_axi_awlen    = awlen_q;
    assign m_axi_awvalid  = awvalid_q;
    assign m_axi_awburst  = 2'b01;
    assign m_axi_awsize   = 3'b010;
    assign m_axi_awcache  = 4'b0011;
    assign m_axi_awprot   = 3'b000;
    // Gated so the data bus reads zero outside a burst (FIFO storage is not reset).
    assign m_axi_wdata    = wvalid_q ? fifo_head : '0;
    assign m_axi_wstrb    = 4'hF;
    assign m_axi_wvalid   = wvalid_q;
    assign m_axi_wlast    = wlast_q;
    assign m_axi_bready   = bready_q;
    assign cap_busy       = busy_q;
    assign cap_frame_done = frame_done_q;
    assign cap_overflow   = overflow_q;
    assign cap_resp_err   = resp_err_q;
`ifdef XILLYVGA_CAP_DBLBUF_EN
    assign cap_buf_sel    = buf_sel_q;
`endif
endmodule

// File: tb/tb_xillyvga_capture.sv
// Bench for xillyvga_capture: drives frames, models an AXI write slave and
// compares every AW / W handshake against queued expectations.
// Latency/backpressure exercised via delayed awready and gated wready.
`timescale 1ns/1ps
module tb_xillyvga_capture;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cap_enable = 1'b0;
    logic [31:0] cap_base = '0;
    logic [23:0] cap_words = '0;
    logic        vid_vsync = 1'b0, vid_de = 1'b0;
    logic [7:0]  vid_red = '0, vid_green = '0, vid_blue = '0;
    logic [31:0] awaddr;
    logic [3:0]  awlen;
    logic        awvalid, awready = 1'b0;
    logic [1:0]  awburst;
    logic [2:0]  awsize;
    logic [3:0]  awcache;
    logic [2:0]  awprot;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wvalid, wlast, wready = 1'b0;
    logic        bvalid = 1'b0;
    logic [1:0]  bresp = 2'b00;
    logic        bready;
    logic        cap_busy, cap_frame_done, cap_overflow, cap_resp_err;

    always #5 clk = ~clk;

    xillyvga_capture dut (
        .m_axi_aclk(clk), .m_axi_aresetn(rst_n),
        .cap_enable(cap_enable), .cap_base(cap_base), .cap_words(cap_words),
        .vid_vsync(vid_vsync), .vid_de(vid_de),
        .vid_red(vid_red), .vid_green(vid_green), .vid_blue(vid_blue),
        .m_axi_awaddr(awaddr), .m_axi_awlen(awlen), .m_axi_awvalid(awvalid),
        .m_axi_awready(awready), .m_axi_awburst(awburst), .m_axi_awsize(awsize),
        .m_axi_awcache(awcache), .m_axi_awprot(awprot),
        .m_axi_wdata(wdata), .m_axi_wstrb(wstrb), .m_axi_wvalid(wvalid),
        .m_axi_wlast(wlast), .m_axi_wready(wready),
        .m_axi_bvalid(bvalid), .m_axi_bresp(bresp), .m_axi_bready(bready),
        .cap_busy(cap_busy), .cap_frame_done(cap_frame_done),
        .cap_overflow(cap_overflow), .cap_resp_err(cap_resp_err)
    );

    typedef struct packed { logic [31:0] addr; logic [3:0] len; } aw_t;
    typedef struct packed { logic [31:0] data; logic last; } w_t;
    aw_t aw_q[$];
    w_t  w_q[$];
    aw_t ea;
    w_t  ew;

    int checks = 0, errors = 0, fd_cnt = 0;
    int aw_delay = 0, aw_wait = 0, wr_mode = 0;
    logic err_once = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] pix(input int i);
        logic [7:0] b;
        b = i[7:0];
        return {8'h00, b, ~b, b + 8'h30};
    endfunction

    task automatic tick(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic expect_words(input int n);
        for (int i = 0; i < n; i++) w_q.push_back({pix(i), ((i % 16) == 15) || (i == n - 1)});
    endtask

    task automatic send_frame(input int n);
        vid_vsync = 1'b1; tick(1);
        vid_vsync = 1'b0; tick(2);
        for (int i = 0; i < n; i++) begin
            vid_de = 1'b1;
            {vid_red, vid_green, vid_blue} = pix(i)[23:0];
            tick(1);
        end
        vid_de = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int k;
        k = 0;
        while (cap_busy && k < 3000) begin tick(1); k++; end
        check({name, "_idle"}, cap_busy, 0);
        tick(3);
        check({name, "_aw_left"}, aw_q.size(), 0);
        check({name, "_w_left"}, w_q.size(), 0);
    endtask

    // Monitor: compares every handshake with the head of the expectation queues.
    initial forever begin
        @(negedge clk);
        if (rst_n) begin
            if (awvalid && awready) begin
                check("aw_pending", aw_q.size() > 0, 1);
                if (aw_q.size() > 0) begin
                    ea = aw_q.pop_front();
                    check("awaddr", awaddr, ea.addr);
                    check("awlen", awlen, ea.len);
                end
            end
            if (wvalid && wready) begin
                check("w_pending", w_q.size() > 0, 1);
                if (w_q.size() > 0) begin
                    ew = w_q.pop_front();
                    check("wdata", wdata, ew.data);
                    check("wlast", wlast, ew.last);
                end
            end
            if (cap_frame_done) fd_cnt++;
        end
    end

    // AXI slave: awready after aw_delay cycles of awvalid.
    initial forever begin
        @(posedge clk); #1;
        if (!rst_n || !awvalid) begin awready = 1'b0; aw_wait = 0; end
        else if (aw_wait >= aw_delay) awready = 1'b1;
        else begin awready = 1'b0; aw_wait++; end
    end

    // wready: 0 = always ready, 1 = toggling, 2 = held low.
    initial forever begin
        @(posedge clk); #1;
        case (wr_mode)
            0:       wready = 1'b1;
            1:       wready = ~wready;
            default: wready = 1'b0;
        endcase
    end

    // B channel: one response per bready request, error on the first if err_once.
    initial forever begin
        @(posedge clk); #1;
        if (!rst_n) bvalid = 1'b0;
        else if (bvalid) bvalid = 1'b0;
        else if (bready) begin
            bvalid   = 1'b1;
            bresp    = err_once ? 2'b10 : 2'b00;
            err_once = 1'b0;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached, errors=%0d checks=%0d", errors, checks);
        $fatal(1, "watchdog");
    end

    initial begin
        tick(3);
        check("rst_awvalid", awvalid, 0);
        check("rst_wvalid", wvalid, 0);
        check("rst_wlast", wlast, 0);
        check("rst_bready", bready, 0);
        check("rst_busy", cap_busy, 0);
        check("rst_done", cap_frame_done, 0);
        check("rst_ovf", cap_overflow, 0);
        check("rst_err", cap_resp_err, 0);
        check("rst_awaddr", awaddr, 0);
        check("rst_awlen", awlen, 0);
        check("rst_wdata", wdata, 0);
        check("awburst", awburst, 2'b01);
        check("awsize", awsize, 3'b010);
        check("awcache", awcache, 4'b0011);
        check("awprot", awprot, 3'b000);
        check("wstrb", wstrb, 4'hF);
        rst_n = 1'b1;
        cap_enable = 1'b1;
        tick(2);

        // Two full bursts.
        cap_base = 32'h1000_0000; cap_words = 24'd32;
        aw_q.push_back({32'h1000_0000, 4'd15});
        aw_q.push_back({32'h1000_0040, 4'd15});
        expect_words(32);
        send_frame(32);
        wait_idle("f32");
        check("f32_done", fd_cnt, 1);

        // Short final burst, unaligned base, slow AW and toggling W.
        aw_delay = 5; wr_mode = 1;
        cap_base = 32'h2000_0013; cap_words = 24'd20;
        aw_q.push_back({32'h2000_0000, 4'd15});
        aw_q.push_back({32'h2000_0040, 4'd3});
        expect_words(20);
        send_frame(20);
        wait_idle("f20");
        check("f20_done", fd_cnt, 2);
        aw_delay = 0; wr_mode = 0;

        // Empty frame completes at once.
        cap_words = 24'd0;
        send_frame(0);
        tick(4);
        check("f0_done", fd_cnt, 3);
        check("f0_busy", cap_busy, 0);

        // Error response on first burst.
        cap_base = 32'h3000_0000; cap_words = 24'd32;
        check("err_pre", cap_resp_err, 0);
        err_once = 1'b1;
        aw_q.push_back({32'h3000_0000, 4'd15});
        aw_q.push_back({32'h3000_0040, 4'd15});
        expect_words(32);
        send_frame(32);
        wait_idle("ferr");
        check("err_set", cap_resp_err, 1);
        check("ferr_done", fd_cnt, 4);
        cap_enable = 1'b0; tick(2);
        check("err_clr", cap_resp_err, 0);
        cap_enable = 1'b1; tick(1);

        // Enable dropped mid-frame: first burst finishes, no frame_done.
        cap_base = 32'h4000_0000; cap_words = 24'd64;
        aw_q.push_back({32'h4000_0000, 4'd15});
        expect_words(16);
        send_frame(20);
        cap_enable = 1'b0;
        wait_idle("fabort");
        check("fabort_done", fd_cnt, 4);
        cap_enable = 1'b1; tick(1);

        // Overflow: W stalled while 100 pixels stream in; 64 survive.
        wr_mode = 2;
        cap_base = 32'h5000_0000; cap_words = 24'd100;
        aw_q.push_back({32'h5000_0000, 4'd15});
        aw_q.push_back({32'h5000_0040, 4'd15});
        aw_q.push_back({32'h5000_0080, 4'd15});
        aw_q.push_back({32'h5000_00C0, 4'd15});
        expect_words(64);
        send_frame(100);
        tick(100);
        check("ovf_set", cap_overflow, 1);
        check("ovf_busy", cap_busy, 1);
        wr_mode = 0;
        wait_idle("fovf");
        check("fovf_done", fd_cnt, 5);
        check("ovf_sticky", cap_overflow, 1);
        cap_enable = 1'b0; tick(2);
        check("ovf_clr", cap_overflow, 0);
        cap_enable = 1'b1; tick(1);

        // Reset while a burst is stalled in DATA.
        wr_mode = 2;
        cap_base = 32'h6000_0000; cap_words = 24'd32;
        aw_q.push_back({32'h6000_0000, 4'd15});
        send_frame(32);
        tick(5);
        check("rdata_wvalid", wvalid, 1);
        rst_n = 1'b0;
        #2;
        check("rmid_awvalid", awvalid, 0);
        check("rmid_wvalid", wvalid, 0);
        check("rmid_wlast", wlast, 0);
        check("rmid_bready", bready, 0);
        check("rmid_busy", cap_busy, 0);
        check("rmid_awaddr", awaddr, 0);
        check("rmid_awlen", awlen, 0);
        check("rmid_wdata", wdata, 0);
        tick(2);
        w_q.delete();
        wr_mode = 0;
        rst_n = 1'b1;
        tick(50);
        check("rpost_busy", cap_busy, 0);
        check("rpost_aw_left", aw_q.size(), 0);
        check("rpost_done", fd_cnt, 5);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
